trace_field_extractor: RTL
==========================

TRACE_FIELD_EXTRACTOR -- requirements
Module: trace_field_extractor

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state updates on posedge clk.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 char  input  8  ASCII character, one per cycle; the same stream that feeds cpu_checker.
REQ-005 format_type  input  2  cpu_checker verdict; 00 none, 01 register write, 10 memory write.
REQ-006 valid  output  1  one-cycle pulse; field outputs hold a newly committed line.
REQ-007 kind  output  2  committed format_type value.
REQ-008 time  output  16  decimal time field, binary value.
REQ-009 pc  output  32  hex pc field.
REQ-010 grf  output  16  decimal register number; 0 when kind=10.
REQ-011 addr  output  32  hex address; 0 when kind=01.
REQ-012 data  output  32  hex data field.
REQ-013 err  output  2  range-check flags: bit0 pc, bit1 grf/addr.
REQ-014 line_count  output  16  committed lines, saturating at 16'hffff.

Function
REQ-015 SHALL run a field-select FSM with states IDLE, TIME, PC, GRF, ADDR, DATA, driven only by delimiters.
REQ-016 Transitions: '^' -> TIME and clear all shadow fields; '@' -> PC; '$' -> GRF; '*' -> ADDR; '=' -> DATA; '#' -> IDLE; these apply from any state.
REQ-017 Digit handling: decimal digits in TIME/GRF give shadow = shadow*10 + d, truncated to 16 bits; hex digits 0-9 and a-f in PC/ADDR/DATA give shadow = {shadow[27:0], d}; the FSM ignores digits in IDLE.
REQ-018 The FSM ignores all other characters (space, ':', '<', others) without changing state or shadows.
REQ-019 Commit: at the edge where format_type != 00 is sampled, SHALL copy the shadows to the outputs, set kind=format_type and pulse valid high for exactly the following cycle.
REQ-020 Latency: '#' sampled at edge N -> format_type nonzero in cycle N..N+1 -> commit at edge N+1 -> valid high in cycle N+1..N+2.
REQ-021 When kind=01, addr SHALL commit as 0; when kind=10, grf SHALL commit as 0.
REQ-022 A commit edge that coincides with '^' SHALL commit the pre-clear shadow values; the clear takes effect in the same edge.
REQ-023 Outputs other than valid SHALL hold their last committed values until the next commit.
REQ-024 line_count SHALL increment on each commit and saturate at 16'hffff without wrapping.
REQ-025 format_type = 11 SHALL be treated as 00 (no commit).

Reset
REQ-026 Reset SHALL force FSM=IDLE, all shadows=0, valid=0, kind=00, time=0, pc=0, grf=0, addr=0, data=0, err=00, line_count=0.
REQ-027 Reset SHALL win over a coincident commit, and a line interrupted by reset SHALL never commit.

Configuration
REQ-028 With macro TRACE_RANGE_CHECK_EN defined, err is computed at commit time.
REQ-029 err[0] = pc not 4-aligned, or pc outside 32'h00003000..32'h00006ffc.
REQ-030 err[1] = kind 01 with grf > 31, or kind 10 with addr not 4-aligned or addr > 32'h00002ffc.
REQ-031 Without TRACE_RANGE_CHECK_EN, err SHALL be constant 00 and no comparator logic is synthesized.

Structure
REQ-032 Package trace_pkg SHALL hold:
- delimiter character constants;
- field FSM state encoding;
- kind codes 00/01/10;
- pc/addr range limits.
REQ-033 Sub-module trace_digit_decode SHALL map char to {is_dec, is_hex, value[3:0]}.

Verification
REQ-034 "^10@00003000: $ 1 <= 0000000a#" with format_type=01 driven one cycle after '#' -> valid one cycle later; kind=01, time=10, pc=32'h3000, grf=1, addr=0, data=32'ha, err=00.
REQ-035 "^5@00003004: *00000010 <= deadbeef#" with format_type=10 -> kind=10, addr=32'h10, grf=0, data=32'hdeadbeef.
REQ-036 A line with format_type held 00 -> no valid pulse, outputs unchanged, line_count unchanged.
REQ-037 '^' arriving in the commit cycle -> previous line committed intact; next line parses from cleared shadows.
REQ-038 Reset asserted in the middle of a line, then a full valid line -> only the second line commits, line_count=1.
REQ-039 With TRACE_RANGE_CHECK_EN: pc=32'h00003002 and grf=40 -> err=11; without the macro, the same stimulus -> err=00.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg: delimiters, field FSM states, kind codes and range limits for trace_field_extractor
package trace_pkg;
   localparam logic [7:0] C_CARET  = 8'h5e;
   localparam logic [7:0] C_AT     = 8'h40;
   localparam logic [7:0] C_DOLLAR = 8'h24;
   localparam logic [7:0] C_STAR   = 8'h2a;
   localparam logic [7:0] C_EQ     = 8'h3d;
   localparam logic [7:0] C_HASH   = 8'h23;
   typedef enum logic [2:0] {S_IDLE, S_TIME, S_PC, S_GRF, S_ADDR, S_DATA} state_t;
   localparam logic [1:0] K_NONE = 2'b00;
   localparam logic [1:0] K_REG  = 2'b01;
   localparam logic [1:0] K_MEM  = 2'b10;
   localparam logic [31:0] PC_MIN   = 32'h0000_3000;
   localparam logic [31:0] PC_MAX   = 32'h0000_6ffc;
   localparam logic [31:0] ADDR_MAX = 32'h0000_2ffc;
   localparam logic [15:0] GRF_MAX  = 16'd31;
endpackage

// File: rtl/trace_digit_decode.sv
// trace_digit_decode: classifies an ASCII char as decimal/lowercase-hex digit and yields its value
module trace_digit_decode
   import trace_pkg::*;
(
   input  logic [7:0] char,
   output logic       is_dec,
   output logic       is_hex,
   output logic [3:0] value
);
   always_comb begin
      is_dec = char >= 8'h30 && char <= 8'h39;
      is_hex = is_dec || (char >= 8'h61 && char <= 8'h66);
      value  = is_dec ? char[3:0] : 4'(char[3:0] + 4'd9);
   end
endmodule

// File: rtl/trace_field_extractor.sv
// trace_field_extractor: parses a cpu trace char stream into fields, committing on cpu_checker verdict
// Define TRACE_RANGE_CHECK_EN to compute pc/grf/addr range flags on err; otherwise err is 00.
module trace_field_extractor
   import trace_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  char,
   input  logic [1:0]  format_type,
   output logic        valid,
   output logic [1:0]  kind,
   output logic [15:0] time_val,
   output logic [31:0] pc,
   output logic [15:0] grf,
   output logic [31:0] addr,
   output logic [31:0] data,
   output logic [1:0]  err,
   output logic [15:0] line_count
);
   state_t      state;
   logic [15:0] t_sh, grf_sh;
   logic [31:0] pc_sh, addr_sh, data_sh;
   logic        is_dec, is_hex, commit;
   logic [3:0]  d;
   logic [1:0]  err_n;
   trace_digit_decode u_dec (.char(char), .is_dec(is_dec), .is_hex(is_hex), .value(d));
   assign commit = format_type == K_REG || format_type == K_MEM;
`ifdef TRACE_RANGE_CHECK_EN
   always_comb begin
      err_n[0] = pc_sh[1:0] != 2'b00 || pc_sh < PC_MIN || pc_sh > PC_MAX;
      err_n[1] = (format_type == K_REG && grf_sh > GRF_MAX) ||
                 (format_type == K_MEM && (addr_sh[1:0] != 2'b00 || addr_sh > ADDR_MAX));
   end
`else
   assign err_n = 2'b00;
`endif
   // commit reads the shadows before this edge's char update, so a coincident '^' clears afterwards
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         {t_sh, grf_sh, pc_sh, addr_sh, data_sh} <= '0;
         valid      <= 1'b0;
         kind       <= K_NONE;
         time_val   <= '0;
         pc         <= '0;
         grf        <= '0;
         addr       <= '0;
         data       <= '0;
         err        <= 2'b00;
         line_count <= '0;
      end else begin
         valid <= commit;
         if (commit) begin
            kind       <= format_type;
            time_val   <= t_sh;
            pc         <= pc_sh;
            grf        <= format_type == K_MEM ? '0 : grf_sh;
            addr       <= format_type == K_REG ? '0 : addr_sh;
            data       <= data_sh;
            err        <= err_n;
            line_count <= line_count + {15'b0, line_count != 16'hffff};
         end
         if (char == C_CARET) begin
            state <= S_TIME;
            {t_sh, grf_sh, pc_sh, addr_sh, data_sh} <= '0;
         end
         else if (char == C_AT) state <= S_PC;
         else if (char == C_DOLLAR) state <= S_GRF;
         else if (char == C_STAR) state <= S_ADDR;
         else if (char == C_EQ) state <= S_DATA;
         else if (char == C_HASH) state <= S_IDLE;
         else if (is_dec && state == S_TIME) t_sh <= t_sh * 16'd10 + {12'b0, d};
         else if (is_dec && state == S_GRF) grf_sh <= grf_sh * 16'd10 + {12'b0, d};
         else if (is_hex && state == S_PC) pc_sh <= {pc_sh[27:0], d};
         else if (is_hex && state == S_ADDR) addr_sh <= {addr_sh[27:0], d};
         else if (is_hex && state == S_DATA) data_sh <= {data_sh[27:0], d};
      end
   end
endmodule
